systolic_mem_responder: RTL and testbench
=========================================

# systolic_mem_responder

Memory-side responder for the systolic accelerator. It serves the accelerator's read requests on the A and B address ports with one-cycle-latency packed rows, and absorbs result-row writes into region C. A host port with a ready/valid handshake preloads A/B and unloads C. Accelerator traffic always has priority over the host.

## Interface
Parameters:
- data_size, 8, width of one matrix element
- systolic_size, 8, elements per packed row
- memory_data_size, 64, packed row width; must equal data_size*systolic_size
- DEPTH_W, 6, log2 of the number of rows held in each region (A, B, C)
- baseaddr_A, 32'h00000000, word address of row 0 of region A
- baseaddr_B, 32'h40000000, word address of row 0 of region B
- baseaddr_C, 32'h80000000, word address of row 0 of region C

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- memory_address_A  in  32  accelerator read address, region A
- memory_address_B  in  32  accelerator read address, region B
- in_out  in  1  read strobe; A and B addresses are sampled together
- memory_in_a  out  memory_data_size  returned A row
- memory_in_b  out  memory_data_size  returned B row
- rd_valid  out  1  one-cycle pulse: memory_in_a/b carry the data for the previous cycle's strobe
- memory_address_OUT  in  32  accelerator write address, region C
- memory_out  in  memory_data_size  accelerator write data
- out_in  in  1  write strobe
- host_sel  in  2  0=A, 1=B, 2=C, 3=reserved
- host_addr  in  DEPTH_W  row index within the selected region
- host_wdata  in  memory_data_size  host write data
- host_wr  in  1  host write request
- host_rd  in  1  host read request
- host_ready  out  1  host request is accepted this cycle
- host_rdata  out  memory_data_size  host read data
- host_rvalid  out  1  one-cycle pulse that qualifies host_rdata
- addr_err  out  1  sticky out-of-range flag; cleared only by reset
- wr_count  out  16  number of accepted accelerator writes; wraps modulo 2^16

## Operation
- Three arrays, each 2^DEPTH_W rows of memory_data_size bits. Array contents are not reset.
- Address decode: offset = address − base, computed in 32-bit unsigned arithmetic. The access is in range iff offset < 2^DEPTH_W, and the row index is offset[DEPTH_W-1:0]. Addresses are row (word) addresses, not byte addresses.
- Accelerator read (in_out=1):
  - A and B are decoded independently.
  - An in-range side returns its row. An out-of-range side returns all zeros and sets addr_err.
- Accelerator write (out_in=1):
  - In range: C[row] ← memory_out and wr_count increments.
  - Out of range: the write is dropped, addr_err is set, and wr_count is unchanged.
- in_out and out_in may both be high in the same cycle. They target disjoint arrays, so both complete.
- Host arbitration: host_ready = !(in_out | out_in), combinational.
  - A host request is accepted only when host_ready=1.
  - When host_ready=0 the host holds its request, and the request is accepted on the first cycle host_ready=1.
- Host write and host read asserted together: the write takes effect and the read is ignored (no host_rvalid).
- host_sel=3: the request is accepted, has no array effect, sets addr_err, and a read returns zeros with host_rvalid.
- Bit i*data_size +: data_size of a row holds element i. The row is passed through unchanged; there is no reordering.

## Timing
- Reset values: memory_in_a=0, memory_in_b=0, rd_valid=0, host_rdata=0, host_rvalid=0, addr_err=0, wr_count=0. host_ready follows its combinational equation during reset. Reset has priority over every strobe.
- Read latency is 1 cycle. A strobe sampled at edge N gives data and rd_valid=1 after edge N (cycle N+1).
- memory_in_a/b hold their last value until the next strobe. rd_valid is low in any cycle without a preceding strobe.
- Back-to-back strobes give one row per cycle with rd_valid continuously high.
- Writes commit at the sampling edge. Read-after-write to C is visible to any read sampled at a later edge.
- A host read in the same cycle as a host write to the same row is not possible (see Operation). A host read accepted one cycle after an accelerator write to that row returns the new data.
- Host read latency is 1 cycle: accepted at edge N gives host_rdata and host_rvalid in cycle N+1.
- wr_count 16'hFFFF + 1 → 16'h0000.
- Reset asserted mid-burst: outputs clear immediately, since reset is asynchronous. Pending reads are discarded, and no rd_valid is produced after reset deasserts without a new strobe.

## Test plan
- Host preload then accelerator read: host writes A[3]=64'h0807060504030201 and B[3]=64'h1111…; in_out with addresses base_A+3 and base_B+3 → next cycle memory_in_a=64'h0807060504030201, memory_in_b=B[3], rd_valid=1 for exactly one cycle.
- Out of range: in_out with memory_address_A=base_A+64 (DEPTH_W=6) and memory_address_B=base_A → memory_in_a=0, memory_in_b=0, addr_err=1, and it stays 1 after 10 idle cycles.
- Write plus host unload: out_in with memory_address_OUT=base_C+5 and data 64'hDEADBEEF_CAFEF00D → wr_count=1; host read C[5] → host_rvalid with that value one cycle later.
- Arbitration: host_wr held high during 4 consecutive in_out cycles → host_ready=0 for those 4 cycles and the write is accepted on the 5th. A streamed 4-row read shows rd_valid high for 4 contiguous cycles.
- Simultaneous traffic: in_out and out_in together for 8 cycles, with reads of A[0..7] and writes to C[0..7] → all 8 rows returned in order, wr_count=8, all C rows correct.
- Reset mid-burst: assert reset asynchronously between edges during a read burst → all outputs are 0 within the same cycle; after release, rd_valid stays 0 until a new strobe is applied.

Source files
------------

// File: rtl/systolic_mem_responder.sv
// Memory-side responder for the systolic accelerator: A/B row reads, C row writes,
// and a lower-priority host port for preloading A/B and unloading C.
module systolic_mem_responder #(
    parameter int          data_size        = 8,
    parameter int          systolic_size    = 8,
    parameter int          memory_data_size = 64,
    parameter int          DEPTH_W          = 6,
    parameter logic [31:0] baseaddr_A       = 32'h00000000,
    parameter logic [31:0] baseaddr_B       = 32'h40000000,
    parameter logic [31:0] baseaddr_C       = 32'h80000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 memory_address_A,
    input  logic [31:0]                 memory_address_B,
    input  logic                        in_out,
    output logic [memory_data_size-1:0] memory_in_a,
    output logic [memory_data_size-1:0] memory_in_b,
    output logic                        rd_valid,
    input  logic [31:0]                 memory_address_OUT,
    input  logic [memory_data_size-1:0] memory_out,
    input  logic                        out_in,
    input  logic [1:0]                  host_sel,
    input  logic [DEPTH_W-1:0]          host_addr,
    input  logic [memory_data_size-1:0] host_wdata,
    input  logic                        host_wr,
    input  logic                        host_rd,
    output logic                        host_ready,
    output logic [memory_data_size-1:0] host_rdata,
    output logic                        host_rvalid,
    output logic                        addr_err,
    output logic [15:0]                 wr_count
);

    localparam int          ROWS   = 1 << DEPTH_W;
    localparam logic [31:0] ROWS_W = 32'(ROWS);

    logic [memory_data_size-1:0] memA [ROWS];
    logic [memory_data_size-1:0] memB [ROWS];
    logic [memory_data_size-1:0] memC [ROWS];

    logic [31:0]         offA, offB, offC;
    logic                inA, inB, inC;
    logic [DEPTH_W-1:0]  rowA, rowB, rowC;
    logic                accWrite, hostWrite, hostRead, hostAccept;

    logic [memory_data_size-1:0] rdA_q, rdA_d, rdB_q, rdB_d;
    logic                        rdValid_q, rdValid_d;
    logic [memory_data_size-1:0] hostRdata_q, hostRdata_d;
    logic                        hostRvalid_q, hostRvalid_d;
    logic                        addrErr_q, addrErr_d;
    logic [15:0]                 wrCount_q, wrCount_d;

    // Unsigned wrap-around makes any address below the base land far out of range.
    assign offA = memory_address_A   - baseaddr_A;
    assign offB = memory_address_B   - baseaddr_B;
    assign offC = memory_address_OUT - baseaddr_C;
    assign inA  = offA < ROWS_W;
    assign inB  = offB < ROWS_W;
    assign inC  = offC < ROWS_W;
    assign rowA = offA[DEPTH_W-1:0];
    assign rowB = offB[DEPTH_W-1:0];
    assign rowC = offC[DEPTH_W-1:0];

    assign host_ready = !(in_out | out_in);
    assign accWrite   = out_in & inC;
    assign hostAccept = host_ready & (host_wr | host_rd);
    assign hostWrite  = host_ready & host_wr;
    assign hostRead   = host_ready & host_rd & ~host_wr;

    // Array storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (hostWrite && host_sel == 2'd0) memA[host_addr] <= host_wdata;
        if (hostWrite && host_sel == 2'd1) memB[host_addr] <= host_wdata;
        if (accWrite)
            memC[rowC] <= memory_out;
        else if (hostWrite && host_sel == 2'd2)
            memC[host_addr] <= host_wdata;
    end

    always_comb begin
        rdA_d        = rdA_q;
        rdB_d        = rdB_q;
        rdValid_d    = in_out;
        hostRdata_d  = hostRdata_q;
        hostRvalid_d = hostRead;
        wrCount_d    = wrCount_q;
        addrErr_d    = addrErr_q;

        if (in_out) begin
            rdA_d = inA ? memA[rowA] : '0;
            rdB_d = inB ? memB[rowB] : '0;
            if (!inA || !inB) addrErr_d = 1'b1;
        end

        if (out_in) begin
            if (inC) wrCount_d = wrCount_q + 16'd1;
            else     addrErr_d = 1'b1;
        end

        if (hostAccept && host_sel == 2'd3) addrErr_d = 1'b1;

        if (hostRead) begin
            case (host_sel)
                2'd0:    hostRdata_d = memA[host_addr];
                2'd1:    hostRdata_d = memB[host_addr];
                2'd2:    hostRdata_d = memC[host_addr];
                default: hostRdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdA_q        <= '0;
            rdB_q        <= '0;
            rdValid_q    <= 1'b0;
            hostRdata_q  <= '0;
            hostRvalid_q <= 1'b0;
            addrErr_q    <= 1'b0;
            wrCount_q    <= '0;
        end else begin
            rdA_q        <= rdA_d;
            rdB_q        <= rdB_d;
            rdValid_q    <= rdValid_d;
            hostRdata_q  <= hostRdata_d;
            hostRvalid_q <= hostRvalid_d;
            addrErr_q    <= addrErr_d;
            wrCount_q    <= wrCount_d;
        end
    end

    // Rows pass through element by element with no reordering.
    for (genvar i = 0; i < systolic_size; i++) begin : g_elem
        assign memory_in_a[i*data_size +: data_size] = rdA_q[i*data_size +: data_size];
        assign memory_in_b[i*data_size +: data_size] = rdB_q[i*data_size +: data_size];
    end

    assign rd_valid    = rdValid_q;
    assign host_rdata  = hostRdata_q;
    assign host_rvalid = hostRvalid_q;
    assign addr_err    = addrErr_q;
    assign wr_count    = wrCount_q;

endmodule

// File: tb/tb_systolic_mem_responder.sv
// Directed self-checking bench for systolic_mem_responder with hand-computed expectations.
module tb_systolic_mem_responder;

    localparam logic [31:0] BASE_A = 32'h00000000;
    localparam logic [31:0] BASE_B = 32'h40000000;
    localparam logic [31:0] BASE_C = 32'h80000000;
    localparam logic [63:0] ROW_B3 = 64'h1111111111111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memory_address_A, memory_address_B, memory_address_OUT;
    logic        in_out, out_in;
    logic [63:0] memory_in_a, memory_in_b, memory_out;
    logic        rd_valid;
    logic [1:0]  host_sel;
    logic [5:0]  host_addr;
    logic [63:0] host_wdata, host_rdata;
    logic        host_wr, host_rd, host_ready, host_rvalid, addr_err;
    logic [15:0] wr_count;

    int testsRun = 0;
    int testsFailed = 0;

    systolic_mem_responder dut (
        .clk(clk), .reset(reset),
        .memory_address_A(memory_address_A), .memory_address_B(memory_address_B),
        .in_out(in_out), .memory_in_a(memory_in_a), .memory_in_b(memory_in_b),
        .rd_valid(rd_valid), .memory_address_OUT(memory_address_OUT),
        .memory_out(memory_out), .out_in(out_in), .host_sel(host_sel),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_wr(host_wr),
        .host_rd(host_rd), .host_ready(host_ready), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .addr_err(addr_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [31:0] addrA, input logic [31:0] addrB,
                                 input logic wr, input logic [31:0] addrOut, input logic [63:0] wdata);
        in_out             = rd;
        memory_address_A   = addrA;
        memory_address_B   = addrB;
        out_in             = wr;
        memory_address_OUT = addrOut;
        memory_out         = wdata;
    endtask

    task automatic hostWrite(input logic [1:0] sel, input logic [5:0] addr, input logic [63:0] data);
        host_sel   = sel;
        host_addr  = addr;
        host_wdata = data;
        host_wr    = 1'b1;
        tick();
        host_wr    = 1'b0;
    endtask

    task automatic hostReadCheck(input string tag, input logic [1:0] sel, input logic [5:0] addr,
                                 input logic [63:0] expected);
        host_sel  = sel;
        host_addr = addr;
        host_rd   = 1'b1;
        tick();
        host_rd   = 1'b0;
        checkOutput({tag, " rvalid"}, 64'(host_rvalid), 64'd1);
        checkOutput(tag, host_rdata, expected);
    endtask

    function automatic logic [63:0] rowA(input int i);
        return 64'h2020202020202020 + 64'(i) * 64'h0101010101010101;
    endfunction

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        host_sel = '0; host_addr = '0; host_wdata = '0; host_wr = 1'b0; host_rd = 1'b0;
        #12;
        checkOutput("reset memory_in_a", memory_in_a, 64'd0);
        checkOutput("reset memory_in_b", memory_in_b, 64'd0);
        checkOutput("reset rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset host_rvalid", 64'(host_rvalid), 64'd0);
        checkOutput("reset addr_err", 64'(addr_err), 64'd0);
        checkOutput("reset wr_count", 64'(wr_count), 64'd0);
        checkOutput("reset host_ready", 64'(host_ready), 64'd1);
        reset = 1'b0;
        tick();

        // Host preload then one accelerator read
        hostWrite(2'd0, 6'd3, 64'h0807060504030201);
        hostWrite(2'd1, 6'd3, ROW_B3);
        applyStimulus(1'b1, BASE_A + 32'd3, BASE_B + 32'd3, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("read A3", memory_in_a, 64'h0807060504030201);
        checkOutput("read B3", memory_in_b, ROW_B3);
        checkOutput("read rd_valid", 64'(rd_valid), 64'd1);
        checkOutput("read addr_err clear", 64'(addr_err), 64'd0);
        tick();
        checkOutput("read rd_valid drops", 64'(rd_valid), 64'd0);
        checkOutput("read A3 held", memory_in_a, 64'h0807060504030201);

        // Out-of-range reads on both sides
        applyStimulus(1'b1, BASE_A + 32'd64, BASE_A, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("oor A zero", memory_in_a, 64'd0);
        checkOutput("oor B zero", memory_in_b, 64'd0);
        checkOutput("oor addr_err", 64'(addr_err), 64'd1);
        repeat (10) tick();
        checkOutput("oor addr_err sticky", 64'(addr_err), 64'd1);

        // Accelerator write, dropped out-of-range write, host unload
        applyStimulus(1'b0, '0, '0, 1'b1, BASE_C + 32'd5, 64'hDEADBEEFCAFEF00D);
        tick();
        checkOutput("write wr_count", 64'(wr_count), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, BASE_C + 32'd64, 64'h0123012301230123);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("oor write wr_count", 64'(wr_count), 64'd1);
        hostReadCheck("host read C5", 2'd2, 6'd5, 64'hDEADBEEFCAFEF00D);
        tick();
        checkOutput("host rvalid drops", 64'(host_rvalid), 64'd0);

        for (int i = 0; i < 8; i++) hostWrite(2'd0, 6'(i), rowA(i));

        // Held host write during a 4-row read stream
        host_sel = 2'd1; host_addr = 6'd10; host_wdata = 64'h5555AAAA5555AAAA; host_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, BASE_A + 32'(i), BASE_B + 32'd3, 1'b0, '0, '0);
            #1;
            checkOutput($sformatf("arb ready low %0d", i), 64'(host_ready), 64'd0);
            tick();
            checkOutput($sformatf("stream rd_valid %0d", i), 64'(rd_valid), 64'd1);
            checkOutput($sformatf("stream A%0d", i), memory_in_a, rowA(i));
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("arb ready high", 64'(host_ready), 64'd1);
        tick();
        host_wr = 1'b0;
        checkOutput("stream rd_valid end", 64'(rd_valid), 64'd0);
        hostReadCheck("arb write landed", 2'd1, 6'd10, 64'h5555AAAA5555AAAA);

        // Host write and read together: write wins, no rvalid
        host_sel = 2'd1; host_addr = 6'd11; host_wdata = 64'h0123456789ABCDEF;
        host_wr = 1'b1; host_rd = 1'b1;
        tick();
        host_wr = 1'b0; host_rd = 1'b0;
        checkOutput("wr+rd no rvalid", 64'(host_rvalid), 64'd0);
        hostReadCheck("wr+rd write landed", 2'd1, 6'd11, 64'h0123456789ABCDEF);

        // Simultaneous reads of A[0..7] and writes to C[0..7]
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, BASE_A + 32'(i), BASE_B + 32'd3, 1'b1, BASE_C + 32'(i),
                          64'hC0DE000000000000 + 64'(i));
            tick();
            checkOutput($sformatf("simul A%0d", i), memory_in_a, rowA(i));
            checkOutput($sformatf("simul rd_valid %0d", i), 64'(rd_valid), 64'd1);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("simul wr_count", 64'(wr_count), 64'd9);
        for (int i = 0; i < 8; i++)
            hostReadCheck($sformatf("simul C%0d", i), 2'd2, 6'(i), 64'hC0DE000000000000 + 64'(i));

        // Asynchronous reset in the middle of a read burst
        applyStimulus(1'b1, BASE_A + 32'd1, BASE_B + 32'd3, 1'b0, '0, '0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst memory_in_a", memory_in_a, 64'd0);
        checkOutput("midrst memory_in_b", memory_in_b, 64'd0);
        checkOutput("midrst rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("midrst wr_count", 64'(wr_count), 64'd0);
        checkOutput("midrst addr_err", 64'(addr_err), 64'd0);
        checkOutput("midrst host_rdata", host_rdata, 64'd0);
        checkOutput("midrst host_ready", 64'(host_ready), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("midrst host_ready idle", 64'(host_ready), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("postrst rd_valid 1", 64'(rd_valid), 64'd0);
        tick();
        checkOutput("postrst rd_valid 2", 64'(rd_valid), 64'd0);
        applyStimulus(1'b1, BASE_A + 32'd3, BASE_B + 32'd3, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("postrst rd_valid", 64'(rd_valid), 64'd1);
        checkOutput("postrst A3", memory_in_a, rowA(3));
        checkOutput("postrst B3", memory_in_b, ROW_B3);

        // wr_count wraps at 16 bits
        applyStimulus(1'b0, '0, '0, 1'b1, BASE_C + 32'd7, 64'h77);
        repeat (65535) tick();
        checkOutput("wrap wr_count max", 64'(wr_count), 64'hFFFF);
        tick();
        checkOutput("wrap wr_count zero", 64'(wr_count), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("wrap addr_err clear", 64'(addr_err), 64'd0);

        // Reserved host_sel: zeros with rvalid, sets addr_err
        hostReadCheck("host read C7", 2'd2, 6'd7, 64'h77);
        hostReadCheck("reserved sel", 2'd3, 6'd7, 64'd0);
        checkOutput("reserved addr_err", 64'(addr_err), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
